tick_scheduler: RTL

Multi-channel event scheduler driven by the base tick from the 10k prescaler; one tick_in pulse every 10,000 clk cycles.
Each of N_CH channels counts a programmable number of base ticks, then raises a pending event. Periodic or one-shot mode per channel.
Pending events from all channels share a single valid/ready event stream under round-robin arbitration.
Used to sequence the periodic GPS-side tasks (sampling, status reporting, timeouts) from one common timebase.

---
 rtl/tick_scheduler_if.sv | 31 +++
 rtl/tick_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler_if.sv
// Handshake bundle for tick_scheduler.
//   cfg_*  : configuration write channel (host -> scheduler), valid/ready.
//   evt_*  : event stream (scheduler -> consumer), valid/ready.
// The slave modport is the scheduler side; master is the host/consumer side.
interface tick_scheduler_if #(
    parameter int N_CH     = 4,
    parameter int PERIOD_W = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic                cfg_enable;
    logic                cfg_oneshot;
    logic [PERIOD_W-1:0] cfg_period;

    logic                evt_valid;
    logic [CH_W-1:0]     evt_ch;
    logic                evt_ready;

    modport master (
        output cfg_valid, cfg_ch, cfg_enable, cfg_oneshot, cfg_period, evt_ready,
        input  cfg_ready, evt_valid, evt_ch
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_enable, cfg_oneshot, cfg_period, evt_ready,
        output cfg_ready, evt_valid, evt_ch
    );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler. Each channel counts base ticks (tick_in) and
// raises a pending event after its programmed period, either periodically or
// once. Pending events share one valid/ready stream under round-robin order.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tick_in    : one-cycle base tick from the prescaler
//   bus        : cfg write channel and event stream (slave modport)
//   armed      : per-channel armed state
//   overrun    : sticky, channel fired while its previous event was pending
module tick_scheduler #(
    parameter int N_CH     = 4,
    parameter int PERIOD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    tick_scheduler_if.slave   bus,
    output logic [N_CH-1:0]   armed,
    output logic [N_CH-1:0]   overrun
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    state_e              state_q  [N_CH];
    state_e              state_d  [N_CH];
    logic [PERIOD_W-1:0] cnt_q    [N_CH];
    logic [PERIOD_W-1:0] cnt_d    [N_CH];
    logic [PERIOD_W-1:0] period_q [N_CH];
    logic [PERIOD_W-1:0] period_d [N_CH];
    logic [N_CH-1:0]     mode_q, mode_d;
    logic [N_CH-1:0]     pending_q, pending_d;
    logic [N_CH-1:0]     overrun_q, overrun_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic                hold_q, hold_d;
    logic [CH_W-1:0]     hold_ch_q, hold_ch_d;

    logic [N_CH-1:0]     fire;
    logic [N_CH-1:0]     cfg_hit;
    logic                cfg_acc;
    logic                evt_hs;
    logic                evt_valid_w;
    logic [CH_W-1:0]     evt_ch_w;
    logic [CH_W-1:0]     rr_ch;
    logic                rr_found;
    logic [CH_W:0]       rr_cand;

    assign cfg_acc        = bus.cfg_valid && cfg_ready_q;
    assign evt_valid_w    = |pending_q;
    // Once presented and not yet accepted, the channel is frozen so a newly
    // pending higher-priority channel cannot change evt_ch mid-handshake.
    assign evt_ch_w       = hold_q ? hold_ch_q : rr_ch;
    assign evt_hs         = evt_valid_w && bus.evt_ready;
    assign bus.evt_valid  = evt_valid_w;
    assign bus.evt_ch     = evt_ch_w;
    assign bus.cfg_ready  = cfg_ready_q;
    assign overrun        = overrun_q;

    // Round-robin pick: first pending channel after last_grant, wrapping.
    // One extra bit keeps the sum exact for non-power-of-two N_CH.
    always_comb begin
        rr_ch    = '0;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rr_cand = {1'b0, last_grant_q} + (CH_W+1)'(i + 1);
            if (rr_cand >= (CH_W+1)'(N_CH)) begin
                rr_cand = rr_cand - (CH_W+1)'(N_CH);
            end
            if (!rr_found && pending_q[rr_cand[CH_W-1:0]]) begin
                rr_found = 1'b1;
                rr_ch    = rr_cand[CH_W-1:0];
            end
        end
    end

    // Per-channel next state; a cfg write to a channel masks that cycle's tick.
    always_comb begin
        fire    = '0;
        cfg_hit = '0;
        mode_d  = mode_q;
        armed   = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_d[ch]  = state_q[ch];
            cnt_d[ch]    = cnt_q[ch];
            period_d[ch] = period_q[ch];
            armed[ch]    = (state_q[ch] == ARMED);
            cfg_hit[ch]  = cfg_acc && (bus.cfg_ch == CH_W'(ch));
            if (cfg_hit[ch]) begin
                if (bus.cfg_enable && (bus.cfg_period != '0)) begin
                    state_d[ch]  = ARMED;
                    cnt_d[ch]    = bus.cfg_period;
                    period_d[ch] = bus.cfg_period;
                    mode_d[ch]   = bus.cfg_oneshot;
                end else begin
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = '0;
                end
            end else if ((state_q[ch] == ARMED) && tick_in) begin
                if (cnt_q[ch] == PERIOD_W'(1)) begin
                    fire[ch] = 1'b1;
                    if (mode_q[ch]) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = period_q[ch];
                    end
                end else begin
                    cnt_d[ch] = cnt_q[ch] - PERIOD_W'(1);
                end
            end
        end
    end

    // Pending/overrun: set beats clear; firing onto an ungranted pending
    // event merges it and flags overrun.
    always_comb begin
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        cfg_ready_d  = 1'b1;
        last_grant_d = evt_hs ? evt_ch_w : last_grant_q;
        hold_d       = evt_valid_w && !bus.evt_ready;
        hold_ch_d    = evt_ch_w;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (evt_hs && (evt_ch_w == CH_W'(ch))) begin
                pending_d[ch] = 1'b0;
            end
            if (cfg_hit[ch]) begin
                overrun_d[ch] = 1'b0;
            end else if (fire[ch] && pending_d[ch]) begin
                overrun_d[ch] = 1'b1;
            end
            if (fire[ch]) begin
                pending_d[ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch]  <= IDLE;
                cnt_q[ch]    <= '0;
                period_q[ch] <= '0;
            end
            mode_q       <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            cfg_ready_q  <= 1'b0;
            last_grant_q <= CH_W'(N_CH - 1);
            hold_q       <= 1'b0;
            hold_ch_q    <= '0;
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch]  <= state_d[ch];
                cnt_q[ch]    <= cnt_d[ch];
                period_q[ch] <= period_d[ch];
            end
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            cfg_ready_q  <= cfg_ready_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            hold_ch_q    <= hold_ch_d;
        end
    end
endmodule
